// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, 1/2 stop, optional parity under UART_TX_PARITY_EN) with a one-word holding register.
// Start bit leaves one cycle after an idle handshake; tx_ready drops while the holding register is full, so frames chain back-to-back.
module uart_tx_cfg #(
   parameter int CLK_FREQ  = 12_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ / BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 r_state;
   logic [DATA_BITS-1:0]   r_hold;
   logic                   r_hold_full;
   logic [DATA_BITS-1:0]   r_shift;
   logic [CNT_W-1:0]       r_cnt;
   logic [3:0]             r_idx;
   logic                   r_tx_out;
   logic                   r_busy;

   logic                   w_bit_end;
   logic [DATA_BITS-1:0]   w_shift_nxt;

`ifdef UART_TX_PARITY_EN
   logic                   r_par;
   logic                   w_par_ld;

   // Parity is taken from the held word so it is ready before the data bits shift out.
   assign w_par_ld = (PARITY == 2) ? ~(^r_hold) : (^r_hold);
`endif

   assign w_bit_end   = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_shift_nxt = r_shift >> 1;

   assign tx_ready = ~r_hold_full;
   assign tx_out   = r_tx_out;
   assign tx_busy  = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_tx_out    <= 1'b1;
         r_busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         if (tx_valid && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
         end

         if (r_state != S_IDLE) begin
            r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               r_tx_out <= 1'b1;
               r_busy   <= 1'b0;
               if (r_hold_full) begin
                  r_state     <= S_START;
                  r_shift     <= r_hold;
                  r_hold_full <= 1'b0;
                  r_cnt       <= '0;
                  r_tx_out    <= 1'b0;
                  r_busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  r_par       <= w_par_ld;
`endif
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_state  <= S_DATA;
                  r_idx    <= '0;
                  r_tx_out <= r_shift[0];
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  if (r_idx == 4'(DATA_BITS - 1)) begin
                     r_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     if (PARITY != 0) begin
                        r_state  <= S_PARITY;
                        r_tx_out <= r_par;
                     end else begin
                        r_state  <= S_STOP;
                        r_tx_out <= 1'b1;
                     end
`else
                     r_state  <= S_STOP;
                     r_tx_out <= 1'b1;
`endif
                  end else begin
                     r_idx    <= r_idx + 4'd1;
                     r_shift  <= w_shift_nxt;
                     r_tx_out <= w_shift_nxt[0];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state  <= S_STOP;
                  r_idx    <= '0;
                  r_tx_out <= 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (w_bit_end) begin
                  if (r_idx == 4'(STOP_BITS - 1)) begin
                     r_idx <= '0;
                     // A word waiting in the holding register starts immediately, no idle cycle.
                     if (r_hold_full) begin
                        r_state     <= S_START;
                        r_shift     <= r_hold;
                        r_hold_full <= 1'b0;
                        r_tx_out    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_par       <= w_par_ld;
`endif
                     end else begin
                        r_state  <= S_IDLE;
                        r_tx_out <= 1'b1;
                        r_busy   <= 1'b0;
                     end
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end

            default: begin
               r_state  <= S_IDLE;
               r_tx_out <= 1'b1;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five parameter sets driven in parallel, each with a queue-based frame scoreboard.
module tb_uart_tx_cfg;

   typedef struct {
      int          a;
      int          s;
      logic [15:0] bits;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   for (genvar gi = 0; gi < 5; gi++) begin : g_cfg
      localparam int CF  = (gi == 0) ? 12_000_000 : (gi == 4) ? 250 : 400;
      localparam int BD  = (gi == 0) ? 3_000_000 : 100;
      localparam int CPB = CF / BD;
      localparam int DB  = (gi == 0) ? 8 : (gi == 1) ? 5 : (gi == 4) ? 9 : 7;
      localparam int SB  = (gi == 1 || gi == 4) ? 2 : 1;
      localparam int PR  = (gi == 2) ? 1 : (gi == 3 || gi == 4) ? 2 : 0;
`ifdef UART_TX_PARITY_EN
      localparam int PA  = (PR != 0) ? 1 : 0;
`else
      localparam int PA  = 0;
`endif
      localparam int NB  = 1 + DB + PA + SB;
      localparam int F   = NB * CPB;
      localparam logic [8:0] FIRST_W = (gi == 0) ? 9'h055 : (gi == 1) ? 9'h01F :
                                       (gi == 4) ? 9'h1AB : 9'h007;

      logic          rst_n_g  = 1'b0;
      logic          tx_valid = 1'b0;
      logic [DB-1:0] tx_data  = '0;
      logic          tx_ready;
      logic          tx_out;
      logic          tx_busy;
      ent_t          q[$];
      int            last_s = -1000000;
      bit            fin = 1'b0;

      uart_tx_cfg #(
         .CLK_FREQ (CF),
         .BAUD     (BD),
         .DATA_BITS(DB),
         .STOP_BITS(SB),
         .PARITY   (PR)
      ) dut (
         .clk     (clk),
         .rst_n   (rst_n_g),
         .tx_data (tx_data),
         .tx_valid(tx_valid),
         .tx_ready(tx_ready),
         .tx_out  (tx_out),
         .tx_busy (tx_busy)
      );

      // Line symbols of one frame: start, data LSB first, optional parity, stop bits.
      function automatic logic [15:0] frame(input logic [8:0] w);
         logic [15:0] b;
         int          ones;
         b    = '1;
         b[0] = 1'b0;
         ones = 0;
         for (int k = 0; k < DB; k++) begin
            b[1+k] = w[k];
            ones  += int'(w[k]);
         end
         if (PA == 1) b[1+DB] = (PR == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
         return b;
      endfunction

      // Holding register is full from the accept edge until the frame start edge.
      function automatic bit model_full(input int p);
         foreach (q[k]) if (q[k].a <= p && q[k].s > p) return 1'b1;
         return 1'b0;
      endfunction

      task automatic drive(input bit v, input logic [8:0] d, output bit acc);
         ent_t e;
         @(negedge clk);
         tx_valid = v;
         tx_data  = d[DB-1:0];
         acc      = 1'b0;
         if (v && !model_full(cyc)) begin
            e.a    = cyc + 1;
            e.s    = (e.a + 1 > last_s + F) ? e.a + 1 : last_s + F;
            e.bits = frame(d);
            last_s = e.s;
            q.push_back(e);
            acc    = 1'b1;
         end
      endtask

      task automatic send(input logic [8:0] d);
         bit acc;
         int t;
         acc = 1'b0;
         t   = 0;
         while (!acc && t < 3000) begin
            drive(1'b1, d, acc);
            t++;
         end
         if (!acc) timeout_fail($sformatf("cfg%0d send", gi));
      endtask

      task automatic wait_idle();
         bit acc;
         int t;
         t = 0;
         while (q.size() > 0 && t < 3000) begin
            drive(1'b0, 9'($urandom), acc);
            t++;
         end
         if (q.size() > 0) timeout_fail($sformatf("cfg%0d drain", gi));
         repeat (3) drive(1'b0, 9'($urandom), acc);
      endtask

      always @(negedge clk) begin : mon
         int   off;
         logic eb;
         logic eo;
         if (rst_n_g === 1'b1) begin
            eb = 1'b0;
            eo = 1'b1;
            if (q.size() > 0 && cyc >= q[0].s) begin
               off = cyc - q[0].s;
               eb  = 1'b1;
               eo  = q[0].bits[off / CPB];
               if (off >= F - 1) void'(q.pop_front());
            end
            chk($sformatf("cfg%0d tx_busy", gi), tx_busy, eb);
            chk($sformatf("cfg%0d tx_out", gi), tx_out, eo);
            chk($sformatf("cfg%0d tx_ready", gi), tx_ready, !model_full(cyc));
         end
      end

      initial begin : stim
         bit acc;
         int s1;
         int t;
         repeat (3) @(negedge clk);
         rst_n_g = 1'b1;
         wait_idle();

         send(FIRST_W);
         wait_idle();

         send(9'h0A5);
         send(9'h03C);
         wait_idle();

         // Reset during data bit 3 with a second word sitting in the holding register.
         send(9'($urandom));
         s1 = last_s;
         send(9'($urandom));
         t = 0;
         while (cyc < s1 + 4 * CPB + 1 && t < 500) begin
            drive(1'b0, 9'($urandom), acc);
            t++;
         end
         #1 rst_n_g = 1'b0;
         #1;
         chk($sformatf("cfg%0d reset tx_out", gi), tx_out, 1'b1);
         chk($sformatf("cfg%0d reset tx_busy", gi), tx_busy, 1'b0);
         chk($sformatf("cfg%0d reset tx_ready", gi), tx_ready, 1'b1);
         q.delete();
         last_s   = -1000000;
         tx_valid = 1'b0;
         repeat (2) @(negedge clk);
         rst_n_g = 1'b1;
         wait_idle();
         send(9'($urandom));
         wait_idle();

         for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 2) != 0, 9'($urandom), acc);
         end
         wait_idle();
         fin = 1'b1;
      end
   end

   initial begin : finisher
      int t;
      t = 0;
      while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin && g_cfg[4].fin)
             && t < 60000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 60000) timeout_fail("overall run");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
